rx_sample_streamer: RTL and testbench
=====================================

# rx_sample_streamer

Parametrised successor to the fixed two-channel RX sample path between the per-modem RX FIFOs and the SMI byte interface. Accepts N channel FIFO read ports of configurable sample width and pulls whole samples. It serialises each sample MSB-first into bytes on a request/valid handshake toward the SMI controller. Channel selection is fixed, round-robin or a counter test pattern.

## Interface
Parameters:
- NUM_CH, 2, number of RX FIFO channels (1..8)
- SAMPLE_W, 32, sample width in bits; multiple of 8, ≥ 8
- CH_W, max(1, clog2(NUM_CH)), derived channel index width (localparam)

Ports:
- i_sys_clk  in  1  system clock; the only clock; FIFO read side is in this domain
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  streaming enable
- i_mode  in  2  00 fixed channel, 01 round-robin, 10 test counter, 11 treated as 00
- i_ch_sel  in  CH_W  channel for fixed mode
- i_fifo_empty  in  NUM_CH  per-channel FIFO empty flag
- i_fifo_data  in  NUM_CH*SAMPLE_W  channel k at [k*SAMPLE_W +: SAMPLE_W]; valid 1 cycle after its pull
- o_fifo_pull  out  NUM_CH  one-hot read strobe, one cycle per sample
- i_byte_req  in  1  single-cycle consumer request for the next byte
- o_byte  out  8  current byte
- o_byte_valid  out  1  o_byte holds an unconsumed byte
- o_sample_ch  out  CH_W  channel of the sample being served
- o_sample_count  out  16  samples fully served; wraps
- i_clear_status  in  1  clears o_underrun
- o_underrun  out  1  sticky: a byte request arrived while o_byte_valid = 0

## Operation
- Reset: all outputs are 0, and the state is IDLE. The round-robin pointer, the test counter and the sample count are 0. Reset mid-sample discards the partial sample.
- FSM IDLE → PULL → LOAD → SERVE → IDLE.
- IDLE samples i_mode and i_ch_sel, and leaves only if i_enable = 1:
  - Fixed: leave if i_ch_sel < NUM_CH and that FIFO is non-empty. i_ch_sel ≥ NUM_CH: stay IDLE, never pull.
  - Round-robin: search channels ptr, ptr+1, … wrapping modulo NUM_CH. Take the first non-empty one. If all are empty, stay IDLE.
  - Test: always leave. No pull; the sample is the zero-extended test counter; o_sample_ch = 0.
- PULL: o_fifo_pull[ch] = 1 for exactly this cycle. In test mode this cycle is a no-op.
- LOAD:
  - Capture i_fifo_data[ch], or the counter in test mode, into the shift register.
  - Set bytes_left = SAMPLE_W/8.
  - o_byte = sample[SAMPLE_W-1 -: 8]; o_byte_valid = 1.
- SERVE, on i_byte_req:
  - If bytes_left > 1: shift left by 8, decrement bytes_left, present the next byte next cycle; valid stays 1.
  - If bytes_left = 1:
    - o_byte_valid ← 0 and o_sample_count += 1.
    - Round-robin ptr ← (ch+1) mod NUM_CH.
    - Test counter += 1, wrapping at 2^SAMPLE_W.
    - Go to IDLE.
- i_enable falling mid-sample: the current sample is completed; no new pull follows.
- i_mode and i_ch_sel changes take effect only in IDLE.
- FIFO empty is checked only in IDLE. A pull is never issued to an empty FIFO.
- Underrun: i_byte_req with o_byte_valid = 0 sets o_underrun. o_byte is unchanged and no state changes.
- If i_clear_status coincides with a new underrun, set wins.
- o_byte is held after the last byte until the next LOAD.

## Timing
- IDLE decision at edge k → o_fifo_pull high k..k+1 → data captured at edge k+2 → o_byte_valid high after edge k+2.
- Byte handoff: i_byte_req sampled at edge j → the next byte appears on o_byte after edge j.
- Minimum gap: after the last byte is consumed, valid stays 0 for 3 cycles before the next sample's first byte (IDLE, PULL, LOAD).
- Maximum throughput is one byte per cycle within a sample.
- o_sample_count and o_sample_ch are registered and update on the same edge as the state change.

## Test plan
- Reset release, NUM_CH=2, SAMPLE_W=32, fixed ch0, FIFO0 holds 0xA1B2C3D4:
  - Pull0 pulses once.
  - Valid rises 2 cycles later.
  - Four requests yield A1, B2, C3, D4.
  - Count = 1, then valid = 0.
- Round-robin, both FIFOs loaded with 0x11111111 (ch0) and 0x22222222 (ch1), 2 samples each:
  - Served channel order is 0, 1, 0, 1.
  - Count = 4; pulls are strictly one-hot.
- Round-robin with only ch1 non-empty, ptr = 0: ch1 is chosen with no pull on ch0. An empty ch1 afterwards keeps the FSM in IDLE.
- Test mode, SAMPLE_W=16: bytes are 00,00, 00,01, 00,02. No o_fifo_pull ever asserts.
- i_byte_req while valid = 0:
  - o_underrun sets.
  - Simultaneous i_clear_status keeps it set.
  - A later clear alone clears it.
- Mid-op events:
  - i_enable drops after byte 1: bytes 2–4 are still served, then no further pull.
  - i_reset asserted after byte 2: all outputs are 0 immediately (async), and the count is 0.

Source files
------------

// File: rtl/rx_sample_streamer_if.sv
// FIFO read ports, byte handshake and status bundle for rx_sample_streamer.
interface rx_sample_streamer_if #(
   parameter int NUM_CH   = 2,
   parameter int SAMPLE_W = 32
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                         i_enable;
   logic [1:0]                   i_mode;
   logic [CH_W-1:0]              i_ch_sel;
   logic [NUM_CH-1:0]            i_fifo_empty;
   logic [NUM_CH*SAMPLE_W-1:0]   i_fifo_data;
   logic [NUM_CH-1:0]            o_fifo_pull;
   logic                         i_byte_req;
   logic [7:0]                   o_byte;
   logic                         o_byte_valid;
   logic [CH_W-1:0]              o_sample_ch;
   logic [15:0]                  o_sample_count;
   logic                         i_clear_status;
   logic                         o_underrun;

   modport slave (
      input  i_enable, i_mode, i_ch_sel, i_fifo_empty, i_fifo_data,
      input  i_byte_req, i_clear_status,
      output o_fifo_pull, o_byte, o_byte_valid, o_sample_ch,
      output o_sample_count, o_underrun
   );

   modport master (
      output i_enable, i_mode, i_ch_sel, i_fifo_empty, i_fifo_data,
      output i_byte_req, i_clear_status,
      input  o_fifo_pull, o_byte, o_byte_valid, o_sample_ch,
      input  o_sample_count, o_underrun
   );
endinterface

// File: rtl/rx_sample_streamer.sv
// Pulls whole samples from N RX FIFOs and serves them MSB-first as bytes.
module rx_sample_streamer #(
   parameter int NUM_CH   = 2,
   parameter int SAMPLE_W = 32
) (
   input logic i_sys_clk,
   input logic i_reset,
   rx_sample_streamer_if.slave bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int NB   = SAMPLE_W / 8;
   localparam int BL_W = $clog2(NB + 1);

   typedef enum logic [1:0] {IDLE, PULL, LOAD, SERVE} state_t;

   state_t              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d, ptr_q, ptr_d, rr_ch;
   logic                test_q, test_d, rr_q, rr_d;
   logic                rr_found, fix_ok;
   logic [SAMPLE_W-1:0] sh_q, sh_d, tcnt_q, tcnt_d, data_sel;
   logic [BL_W-1:0]     bl_q, bl_d;
   logic                valid_q, valid_d, under_q, under_d;
   logic [15:0]         cnt_q, cnt_d;

   // Lowest offset from ptr wins, so scan offsets from high to low.
   always_comb begin
      logic [CH_W:0] idx;
      idx      = '0;
      rr_found = 1'b0;
      rr_ch    = ptr_q;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = {1'b0, ptr_q} + (CH_W+1)'(i);
         if (idx >= (CH_W+1)'(NUM_CH))
            idx = idx - (CH_W+1)'(NUM_CH);
         if (!bus.i_fifo_empty[idx[CH_W-1:0]]) begin
            rr_found = 1'b1;
            rr_ch    = idx[CH_W-1:0];
         end
      end
   end

   assign fix_ok = (int'(bus.i_ch_sel) < NUM_CH) &&
                   !bus.i_fifo_empty[bus.i_ch_sel];

   assign data_sel = bus.i_fifo_data[int'(ch_q)*SAMPLE_W +: SAMPLE_W];

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      ptr_d   = ptr_q;
      test_d  = test_q;
      rr_d    = rr_q;
      sh_d    = sh_q;
      tcnt_d  = tcnt_q;
      bl_d    = bl_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      under_d = under_q;
      unique case (state_q)
         IDLE: begin
            if (bus.i_enable) begin
               unique case (bus.i_mode)
                  2'b01: begin
                     if (rr_found) begin
                        ch_d    = rr_ch;
                        test_d  = 1'b0;
                        rr_d    = 1'b1;
                        state_d = PULL;
                     end
                  end
                  2'b10: begin
                     ch_d    = '0;
                     test_d  = 1'b1;
                     rr_d    = 1'b0;
                     state_d = PULL;
                  end
                  default: begin
                     if (fix_ok) begin
                        ch_d    = bus.i_ch_sel;
                        test_d  = 1'b0;
                        rr_d    = 1'b0;
                        state_d = PULL;
                     end
                  end
               endcase
            end
         end
         PULL: state_d = LOAD;
         LOAD: begin
            sh_d    = test_q ? tcnt_q : data_sel;
            bl_d    = BL_W'(NB);
            valid_d = 1'b1;
            state_d = SERVE;
         end
         SERVE: begin
            if (bus.i_byte_req) begin
               if (bl_q > BL_W'(1)) begin
                  sh_d = sh_q << 8;
                  bl_d = bl_q - 1'b1;
               end else begin
                  valid_d = 1'b0;
                  cnt_d   = cnt_q + 1'b1;
                  state_d = IDLE;
                  if (rr_q)
                     ptr_d = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
                  if (test_q)
                     tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A request with nothing to serve only flags, it never moves state.
      if (bus.i_byte_req && !valid_q)
         under_d = 1'b1;
      else if (bus.i_clear_status)
         under_d = 1'b0;
   end

   always_ff @(posedge i_sys_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         ch_q    <= '0;
         ptr_q   <= '0;
         test_q  <= 1'b0;
         rr_q    <= 1'b0;
         sh_q    <= '0;
         tcnt_q  <= '0;
         bl_q    <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         under_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
         test_q  <= test_d;
         rr_q    <= rr_d;
         sh_q    <= sh_d;
         tcnt_q  <= tcnt_d;
         bl_q    <= bl_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         under_q <= under_d;
      end
   end

   assign bus.o_fifo_pull    = (state_q == PULL && !test_q) ?
                               (NUM_CH'(1) << ch_q) : '0;
   assign bus.o_byte         = sh_q[SAMPLE_W-1 -: 8];
   assign bus.o_byte_valid   = valid_q;
   assign bus.o_sample_ch    = ch_q;
   assign bus.o_sample_count = cnt_q;
   assign bus.o_underrun     = under_q;
endmodule

// File: tb/tb_rx_sample_streamer.sv
// Scoreboard bench: two streamers (2x32 FIFO paths, 3x16 test mode).
module tb_rx_sample_streamer;
   typedef struct packed {
      logic [7:0] b;
      logic [7:0] ch;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pulls_a = 0, pulls_a0 = 0, pulls_b = 0;
   int   p0, p00, t;
   exp_t exp_a[$], exp_b[$];
   exp_t e;
   logic [31:0] fq[2][$];
   logic [1:0]  pseen;

   rx_sample_streamer_if #(.NUM_CH(2), .SAMPLE_W(32)) ifa ();
   rx_sample_streamer_if #(.NUM_CH(3), .SAMPLE_W(16)) ifb ();

   rx_sample_streamer #(.NUM_CH(2), .SAMPLE_W(32)) dut_a (
      .i_sys_clk(clk), .i_reset(rst), .bus(ifa.slave));
   rx_sample_streamer #(.NUM_CH(3), .SAMPLE_W(16)) dut_b (
      .i_sys_clk(clk), .i_reset(rst), .bus(ifb.slave));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int ch, input logic [31:0] v);
      fq[ch].push_back(v);
      ifa.i_fifo_empty[ch] = 1'b0;
   endtask

   task automatic push_exp(input bit sel, input logic [31:0] v,
                           input int nb, input int take, input int ch);
      exp_t x;
      for (int i = 0; i < take; i++) begin
         x.b  = 8'(v >> (8 * (nb - 1 - i)));
         x.ch = 8'(ch);
         if (sel) exp_b.push_back(x);
         else     exp_a.push_back(x);
      end
   endtask

   task automatic get_byte(input bit sel);
      int k = 0;
      while (!(sel ? ifb.o_byte_valid : ifa.o_byte_valid) && k < 40) begin
         tick();
         k++;
      end
      if (!(sel ? ifb.o_byte_valid : ifa.o_byte_valid)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_valid dut%0d: valid stayed 0, required 1", sel);
      end else begin
         if (sel) ifb.i_byte_req = 1'b1;
         else     ifa.i_byte_req = 1'b1;
         tick();
         ifa.i_byte_req = 1'b0;
         ifb.i_byte_req = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      ifa.i_enable = 0; ifa.i_mode = 0; ifa.i_ch_sel = 0;
      ifa.i_fifo_empty = '1; ifa.i_fifo_data = '0;
      ifa.i_byte_req = 0; ifa.i_clear_status = 0;
      ifb.i_enable = 0; ifb.i_mode = 0; ifb.i_ch_sel = 0;
      ifb.i_fifo_empty = '1; ifb.i_fifo_data = '0;
      ifb.i_byte_req = 0; ifb.i_clear_status = 0;
      fork
         forever begin
            @(negedge clk);
            if (ifa.i_byte_req && ifa.o_byte_valid) begin
               if (exp_a.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL a_extra_byte: got %0h, expected none", ifa.o_byte);
               end else begin
                  e = exp_a.pop_front();
                  chk("a_byte", 32'(ifa.o_byte), 32'(e.b));
                  chk("a_sample_ch", 32'(ifa.o_sample_ch), 32'(e.ch));
               end
            end
            if (ifb.i_byte_req && ifb.o_byte_valid) begin
               if (exp_b.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL b_extra_byte: got %0h, expected none", ifb.o_byte);
               end else begin
                  e = exp_b.pop_front();
                  chk("b_byte", 32'(ifb.o_byte), 32'(e.b));
                  chk("b_sample_ch", 32'(ifb.o_sample_ch), 32'(e.ch));
               end
            end
            if (|ifa.o_fifo_pull) begin
               pulls_a++;
               if (ifa.o_fifo_pull[0]) pulls_a0++;
               chk("a_pull_onehot", 32'($onehot(ifa.o_fifo_pull)), 1);
               for (int k = 0; k < 2; k++)
                  if (ifa.o_fifo_pull[k])
                     chk("a_pull_nonempty", 32'(fq[k].size() != 0), 1);
            end
            if (|ifb.o_fifo_pull) pulls_b++;
         end
         forever begin
            @(negedge clk);
            pseen = ifa.o_fifo_pull;
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
               if (pseen[k] && fq[k].size() > 0)
                  ifa.i_fifo_data[k*32 +: 32] = fq[k].pop_front();
               ifa.i_fifo_empty[k] = (fq[k].size() == 0);
            end
         end
         begin
            tick();
            tick();
            chk("rst_valid", 32'(ifa.o_byte_valid), 0);
            chk("rst_pull", 32'(ifa.o_fifo_pull), 0);
            chk("rst_byte", 32'(ifa.o_byte), 0);
            chk("rst_count", 32'(ifa.o_sample_count), 0);
            chk("rst_ch", 32'(ifa.o_sample_ch), 0);
            chk("rst_underrun", 32'(ifa.o_underrun), 0);
            push(0, 32'hA1B2C3D4);
            push_exp(0, 32'hA1B2C3D4, 4, 4, 0);
            ifa.i_enable = 1;
            p0 = pulls_a;
            rst = 1'b0;
            t = 0;
            while (ifa.o_fifo_pull == 0 && t < 20) begin
               tick();
               t++;
            end
            if (ifa.o_fifo_pull == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL t1_pull_wait: pull stayed 0, required 01");
            end else begin
               chk("t1_pull_ch0", 32'(ifa.o_fifo_pull), 1);
               chk("t1_valid_at_pull", 32'(ifa.o_byte_valid), 0);
               tick();
               chk("t1_pull_one_cycle", 32'(ifa.o_fifo_pull), 0);
               tick();
               chk("t1_valid_2cyc", 32'(ifa.o_byte_valid), 1);
            end
            repeat (4) get_byte(0);
            chk("t1_count", 32'(ifa.o_sample_count), 1);
            chk("t1_valid_low", 32'(ifa.o_byte_valid), 0);
            chk("t1_pulls", 32'(pulls_a - p0), 1);

            ifa.i_enable = 0;
            do_reset();
            push(0, 32'h11111111); push(0, 32'h11111111);
            push(1, 32'h22222222); push(1, 32'h22222222);
            push_exp(0, 32'h11111111, 4, 4, 0);
            push_exp(0, 32'h22222222, 4, 4, 1);
            push_exp(0, 32'h11111111, 4, 4, 0);
            push_exp(0, 32'h22222222, 4, 4, 1);
            ifa.i_mode = 2'b01;
            ifa.i_enable = 1;
            p0 = pulls_a;
            repeat (16) get_byte(0);
            chk("t2_count", 32'(ifa.o_sample_count), 4);
            chk("t2_pulls", 32'(pulls_a - p0), 4);

            ifa.i_enable = 0;
            do_reset();
            push(1, 32'h5A6B7C8D);
            push_exp(0, 32'h5A6B7C8D, 4, 4, 1);
            p0 = pulls_a;
            p00 = pulls_a0;
            ifa.i_enable = 1;
            repeat (4) get_byte(0);
            repeat (8) tick();
            chk("t3_pulls", 32'(pulls_a - p0), 1);
            chk("t3_no_ch0_pull", 32'(pulls_a0 - p00), 0);
            chk("t3_idle_valid", 32'(ifa.o_byte_valid), 0);

            ifa.i_byte_req = 1;
            tick();
            ifa.i_byte_req = 0;
            chk("t4_underrun_set", 32'(ifa.o_underrun), 1);
            chk("t4_byte_held", 32'(ifa.o_byte), 32'h8D);
            ifa.i_byte_req = 1;
            ifa.i_clear_status = 1;
            tick();
            ifa.i_byte_req = 0;
            ifa.i_clear_status = 0;
            chk("t4_set_wins", 32'(ifa.o_underrun), 1);
            ifa.i_clear_status = 1;
            tick();
            ifa.i_clear_status = 0;
            chk("t4_cleared", 32'(ifa.o_underrun), 0);

            ifa.i_enable = 0;
            ifa.i_mode = 2'b00;
            do_reset();
            push(0, 32'h01020304);
            push(0, 32'h05060708);
            push_exp(0, 32'h01020304, 4, 4, 0);
            push_exp(0, 32'h05060708, 4, 2, 0);
            p0 = pulls_a;
            ifa.i_enable = 1;
            get_byte(0);
            ifa.i_enable = 0;
            repeat (3) get_byte(0);
            repeat (8) tick();
            chk("t5_no_new_pull", 32'(pulls_a - p0), 1);
            chk("t5_valid_low", 32'(ifa.o_byte_valid), 0);
            chk("t5_fifo_left", 32'(fq[0].size()), 1);
            chk("t5_count", 32'(ifa.o_sample_count), 1);
            ifa.i_enable = 1;
            repeat (2) get_byte(0);
            chk("t5_valid_mid", 32'(ifa.o_byte_valid), 1);
            rst = 1'b1;
            #2;
            chk("t5_rst_valid", 32'(ifa.o_byte_valid), 0);
            chk("t5_rst_byte", 32'(ifa.o_byte), 0);
            chk("t5_rst_count", 32'(ifa.o_sample_count), 0);
            chk("t5_rst_pull", 32'(ifa.o_fifo_pull), 0);
            chk("t5_rst_ch", 32'(ifa.o_sample_ch), 0);
            ifa.i_enable = 0;
            tick();
            rst = 1'b0;
            tick();

            ifb.i_mode = 2'b10;
            push_exp(1, 32'h0000, 2, 2, 0);
            push_exp(1, 32'h0001, 2, 2, 0);
            push_exp(1, 32'h0002, 2, 2, 0);
            ifb.i_enable = 1;
            repeat (6) get_byte(1);
            ifb.i_enable = 0;
            chk("t6_count_b", 32'(ifb.o_sample_count), 3);
            chk("t6_no_pull_b", 32'(pulls_b), 0);
            repeat (4) tick();
            chk("exp_a_drained", 32'(exp_a.size()), 0);
            chk("exp_b_drained", 32'(exp_b.size()), 0);
         end
      join_any
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
